// File: rtl/streebog_lps_pkg.sv
// Shared definitions for the Streebog LPS core: parameter legality, per-stage
// slice widths, counter widths and the controller state encoding.
package streebog_lps_pkg;

    function automatic bit ps_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8);
    endfunction

    function automatic bit l_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) ||
               (n == 16) || (n == 32) || (n == 64);
    endfunction

    function automatic int ps_w(input int ps_stages);
        return 8 / ps_stages;
    endfunction

    function automatic int l_b(input int l_stages);
        return 64 / l_stages;
    endfunction

    // One-stage counters are absent; their index port stays one bit wide and tied to zero.
    function automatic int cnt_w(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } lps_state_e;

endpackage

// File: rtl/streebog_lps_ctrl.sv
// LPS sequencer: IDLE/RUN/FLUSH FSM, PS and L slice counters, handshake
// outputs and the one-cycle-delayed write offsets matching ROM latency.
module streebog_lps_ctrl
    import streebog_lps_pkg::*;
#(
    parameter int PS_STAGES = 8,
    parameter int L_STAGES  = 8,
    localparam int PS_CW    = cnt_w(PS_STAGES),
    localparam int L_CW     = cnt_w(L_STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic             rdy,
    output logic             last,
    output logic             done,
    output logic [PS_CW-1:0] ps_cnt,
    output logic [L_CW-1:0]  l_cnt,
    output logic             wr_en,
    output logic [PS_CW-1:0] wr_ps,
    output logic [L_CW-1:0]  wr_l
);

    lps_state_e state, state_next;
    logic       ps_wrap, l_wrap;

    assign l_wrap  = (L_STAGES == 1)  || (l_cnt == L_CW'(L_STAGES - 1));
    assign ps_wrap = (PS_STAGES == 1) || (ps_cnt == PS_CW'(PS_STAGES - 1));
    assign rdy     = (state == ST_IDLE);
    assign last    = (state == ST_FLUSH);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ena) state_next = ST_RUN;
            ST_RUN:   if (ps_wrap && l_wrap) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            wr_en <= 1'b0;
            wr_ps <= '0;
            wr_l  <= '0;
        end else begin
            state <= state_next;
            done  <= (state == ST_FLUSH);
            wr_en <= (state == ST_RUN);
            wr_ps <= ps_cnt;
            wr_l  <= l_cnt;
        end
    end

    if (L_STAGES > 1) begin : g_l_cnt
        always_ff @(posedge clk) begin
            if (rst)
                l_cnt <= '0;
            else if (state == ST_RUN)
                l_cnt <= l_wrap ? '0 : l_cnt + 1'b1;
        end
    end else begin : g_no_l_cnt
        assign l_cnt = '0;
    end

    if (PS_STAGES > 1) begin : g_ps_cnt
        always_ff @(posedge clk) begin
            if (rst)
                ps_cnt <= '0;
            else if (state == ST_RUN && l_wrap)
                ps_cnt <= ps_wrap ? '0 : ps_cnt + 1'b1;
        end
    end else begin : g_no_ps_cnt
        assign ps_cnt = '0;
    end

endmodule

// File: rtl/streebog_rom_a_matrix.sv
// Streebog linear-layer matrix A; returns, registered, the 64-bit mask whose
// parity against an input word yields output bit 'addr' of L().
module streebog_rom_a_matrix (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [63:0] row
);

    // Entry i is XORed into the result when input bit (63-i) is set.
    localparam logic [63:0] A [64] = '{
        64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
        64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
        64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
        64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
        64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
        64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
        64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
        64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
        64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
        64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
        64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
        64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
        64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
        64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
        64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
        64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
    };

    logic [63:0] row_c;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        row_c = '0;
        for (int m = 0; m < 64; m++) begin
            row_c[m] = A[63-m][addr];
        end
    end

    always_ff @(posedge clk) begin
        row <= row_c;
    end

endmodule

// File: rtl/streebog_rom_s_table.sv
// Streebog byte substitution table pi, registered read (one-cycle latency).
module streebog_rom_s_table (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // NOTE: ROM output registers carry pure data qualified by the controller, so they take no reset.
    always_ff @(posedge clk) begin
        data <= PI[addr];
    end

endmodule

// File: rtl/streebog_core_lps_v2.sv
// Iterative Streebog LPS transform (dout = L(P(S(din)))) sliced over PS and L.
// Define STREEBOG_LPS_DIN_REG_EN to capture din at accept instead of requiring it held.
module streebog_core_lps_v2
    import streebog_lps_pkg::*;
#(
    parameter int PS_STAGES = 8,
    parameter int L_STAGES  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    output logic         rdy,
    output logic         last,
    output logic         done,
    input  logic [511:0] din,
    output logic [511:0] dout
);

    localparam int PS_W  = ps_w(PS_STAGES);
    localparam int L_B   = l_b(L_STAGES);
    localparam int PS_CW = cnt_w(PS_STAGES);
    localparam int L_CW  = cnt_w(L_STAGES);

    if (!ps_legal(PS_STAGES)) begin : g_bad_ps
        $error("PS_STAGES must be 1, 2, 4 or 8");
    end
    if (!l_legal(L_STAGES)) begin : g_bad_l
        $error("L_STAGES must be a power of two from 1 to 64");
    end

    logic [PS_CW-1:0] ps_cnt, wr_ps;
    logic [L_CW-1:0]  l_cnt, wr_l;
    logic             wr_en;
    logic [511:0]     src;

    streebog_lps_ctrl #(
        .PS_STAGES (PS_STAGES),
        .L_STAGES  (L_STAGES)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .rdy    (rdy),
        .last   (last),
        .done   (done),
        .ps_cnt (ps_cnt),
        .l_cnt  (l_cnt),
        .wr_en  (wr_en),
        .wr_ps  (wr_ps),
        .wr_l   (wr_l)
    );

`ifdef STREEBOG_LPS_DIN_REG_EN
    logic [511:0] din_q;

    always_ff @(posedge clk) begin
        if (ena && rdy && !rst)
            din_q <= din;
    end
    assign src = din_q;
`else
    assign src = din;
`endif

    // S-word w of this slice gathers byte (ps_cnt*PS_W+w) of every input word: that is P.
    logic [PS_W-1:0][7:0][7:0] s_addr;
    logic [L_B-1:0][5:0]       a_addr;
    wire  [PS_W-1:0][63:0]     s_word;
    wire  [L_B-1:0][63:0]      a_row;

    always_comb begin
        s_addr = '0;
        for (int w = 0; w < PS_W; w++) begin
            for (int j = 0; j < 8; j++) begin
                s_addr[w][j] = src[9'(64*j + 8*(int'(ps_cnt)*PS_W + w)) +: 8];
            end
        end
        a_addr = '0;
        for (int b = 0; b < L_B; b++) begin
            a_addr[b] = 6'(int'(l_cnt)*L_B + b);
        end
    end

    for (genvar w = 0; w < PS_W; w++) begin : g_s
        for (genvar j = 0; j < 8; j++) begin : g_byte
            streebog_rom_s_table u_s (
                .clk  (clk),
                .addr (s_addr[w][j]),
                .data (s_word[w][8*j +: 8])
            );
        end
    end

    for (genvar b = 0; b < L_B; b++) begin : g_a
        streebog_rom_a_matrix u_a (
            .clk  (clk),
            .addr (a_addr[b]),
            .row  (a_row[b])
        );
    end

    logic [511:0] dout_next;

    always_comb begin
        dout_next = dout;
        for (int w = 0; w < PS_W; w++) begin
            for (int b = 0; b < L_B; b++) begin
                dout_next[9'(64*(int'(wr_ps)*PS_W + w) + int'(wr_l)*L_B + b)] = ^(a_row[b] & s_word[w]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (wr_en)
            dout <= dout_next;
    end

endmodule

// File: tb/tb_streebog_core_lps_v2.sv
// Self-checking bench for streebog_core_lps_v2: directed scenarios on the default
// build plus a PS x L parameter sweep, all against a byte/word-level LPS model.
module tb_streebog_core_lps_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sweep_fin = 0;

    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    localparam logic [63:0] A_TAB [64] = '{
        64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
        64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
        64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
        64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
        64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
        64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
        64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
        64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
        64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
        64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
        64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
        64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
        64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
        64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
        64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
        64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
    };

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Byte-level S, byte-matrix transpose, then A-row accumulation per word.
    function automatic logic [511:0] lps_model(input logic [511:0] d);
        logic [7:0]   s [64];
        logic [7:0]   p [64];
        logic [63:0]  v, r;
        logic [511:0] o;
        for (int n = 0; n < 64; n++) s[n] = PI[d[8*n +: 8]];
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) p[8*k + j] = s[8*j + k];
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) v[8*j +: 8] = p[8*k + j];
            r = '0;
            for (int i = 0; i < 64; i++) if (v[63-i]) r ^= A_TAB[i];
            o[64*k +: 64] = r;
        end
        return o;
    endfunction

    // ---------------- default-parameter instance: directed scenarios ----------------
    logic         m_rst, m_ena, m_rdy, m_last, m_done;
    logic [511:0] m_din, m_dout;

    streebog_core_lps_v2 u_dut (
        .clk  (clk),
        .rst  (m_rst),
        .ena  (m_ena),
        .rdy  (m_rdy),
        .last (m_last),
        .done (m_done),
        .din  (m_din),
        .dout (m_dout)
    );

    // Compare process: done only with rdy and after last; dout frozen after done until the next accept.
    logic         hold = 1'b0;
    logic         last_q = 1'b0;
    logic [511:0] held = '0;

    always @(posedge clk) begin
        last_q <= m_last;
        if (m_rst || (m_ena && m_rdy)) hold <= 1'b0;
        else if (m_done) begin
            hold <= 1'b1;
            held <= m_dout;
        end
    end

    always @(negedge clk) begin
        if (m_done) begin
            check("done_with_rdy", 512'(m_rdy), 512'(1));
            check("last_before_done", 512'(last_q), 512'(1));
        end
        if (hold) check("dout_stable", m_dout, held);
    end

    task automatic run_op(input logic [511:0] v, output logic [511:0] res, output int lat);
        m_din = v;
        m_ena = 1'b1;
        @(negedge clk);
        m_ena = 1'b0;
        lat = 1;
        while (!m_done && lat < 600) begin
`ifdef STREEBOG_LPS_DIN_REG_EN
            m_din = rand512();
`endif
            @(negedge clk);
            lat++;
        end
        res = m_dout;
    endtask

    initial begin
        logic [511:0] v, v2, res, res2, pin, pin_exp;
        int lat, lat2, n_done;

        m_rst = 1'b1;
        m_ena = 1'b0;
        m_din = '0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 512'(m_rdy), 512'(1));
        check("rst_last", 512'(m_last), 512'(0));
        check("rst_done", 512'(m_done), 512'(0));
        check("rst_dout", m_dout, '0);
        m_rst = 1'b0;

        // 0xA5 -> S 0x00, 0x2D -> S 0x01, 0x7B -> S 0x80: single bits select single A rows.
        pin = {64{8'hA5}};
        check("model_zero", lps_model(pin), '0);
        run_op(pin, res, lat);
        check("zero_dout", res, '0);
        pin[7:0]     = 8'h2D;
        pin[479:472] = 8'h7B;
        pin_exp = '0;
        pin_exp[63:0]    = 64'h641c314b2b8ee083;
        pin_exp[255:192] = 64'h8e20faa72ba0b470;
        check("model_pin", lps_model(pin), pin_exp);
        run_op(pin, res, lat);
        check("pin_dout", res, pin_exp);
        check("pin_latency", 512'(lat), 512'(66));

        v = rand512();
        run_op(v, res, lat);
        check("rand_dout", res, lps_model(v));
        check("rand_latency", 512'(lat), 512'(66));

        v  = rand512();
        v2 = rand512();
        run_op(v, res, lat);
        run_op(v2, res2, lat2);
        check("b2b_first", res, lps_model(v));
        check("b2b_second", res2, lps_model(v2));
        check("b2b_spacing", 512'(lat2), 512'(66));

        v = rand512();
        m_din = v;
        m_ena = 1'b1;
        @(negedge clk);
        m_ena = 1'b0;
        repeat (9) @(negedge clk);
        m_rst = 1'b1;
        @(negedge clk);
        check("abort_rdy", 512'(m_rdy), 512'(1));
        check("abort_dout", m_dout, '0);
        check("abort_last", 512'(m_last), 512'(0));
        m_rst = 1'b0;
        n_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (m_done) n_done++;
        end
        check("abort_no_done", 512'(n_done), 512'(0));
        v = rand512();
        run_op(v, res, lat);
        check("after_abort_dout", res, lps_model(v));
        check("after_abort_latency", 512'(lat), 512'(66));

        v = rand512();
        m_din = v;
        m_ena = 1'b1;
        @(negedge clk);
        n_done = 0;
        lat = 0;
        res = '0;
        for (int c = 1; c <= 100; c++) begin
            m_ena = (c == 5) || (c == 30) || (c == 60);
            if (m_done) begin
                n_done++;
                lat = c;
                res = m_dout;
            end
            @(negedge clk);
        end
        m_ena = 1'b0;
        check("ena_run_one_done", 512'(n_done), 512'(1));
        check("ena_run_latency", 512'(lat), 512'(66));
        check("ena_run_dout", res, lps_model(v));
        check("ena_run_not_queued", 512'(m_rdy), 512'(1));

        for (int t = 0; t < 60000 && sweep_fin < 16; t++) @(negedge clk);
        check("sweep_complete", 512'(sweep_fin), 512'(16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- parameter sweep: PS {1,2,4,8} x L {1,2,8,64} ----------------
    for (genvar gp = 0; gp < 4; gp++) begin : g_ps
        for (genvar gl = 0; gl < 4; gl++) begin : g_l
            localparam int PSV = 1 << gp;
            localparam int LV  = (gl == 0) ? 1 : (gl == 1) ? 2 : (gl == 2) ? 8 : 64;

            logic         s_rst, s_ena, s_rdy, s_last, s_done;
            logic [511:0] s_din, s_dout;

            streebog_core_lps_v2 #(
                .PS_STAGES (PSV),
                .L_STAGES  (LV)
            ) u_sweep (
                .clk  (clk),
                .rst  (s_rst),
                .ena  (s_ena),
                .rdy  (s_rdy),
                .last (s_last),
                .done (s_done),
                .din  (s_din),
                .dout (s_dout)
            );

            initial begin
                logic [511:0] v;
                int lat;
                s_rst = 1'b1;
                s_ena = 1'b0;
                s_din = '0;
                repeat (2) @(negedge clk);
                s_rst = 1'b0;
                for (int n = 0; n < 100; n++) begin
                    v = rand512();
                    s_din = v;
                    s_ena = 1'b1;
                    @(negedge clk);
                    s_ena = 1'b0;
                    lat = 1;
                    while (!s_done && lat < PSV*LV + 10) begin
`ifdef STREEBOG_LPS_DIN_REG_EN
                        s_din = rand512();
`endif
                        @(negedge clk);
                        lat++;
                    end
                    check($sformatf("sweep_%0dx%0d_latency", PSV, LV), 512'(lat), 512'(PSV*LV + 2));
                    check($sformatf("sweep_%0dx%0d_dout", PSV, LV), s_dout, lps_model(v));
                end
                sweep_fin++;
            end
        end
    end

endmodule

// File: doc/streebog_core_lps_v2.md
STREEBOG_CORE_LPS_V2 -- requirements
Module: streebog_core_lps_v2

Interface
REQ-001 Parameter PS_STAGES, default 8, PS pipeline stages; legal 1, 2, 4, 8; words per stage PS_W = 8/PS_STAGES.
REQ-002 Parameter L_STAGES, default 8, L pipeline stages; legal 1, 2, 4, 8, 16, 32, 64; bits per stage L_B = 64/L_STAGES.
REQ-003 An illegal parameter value SHALL cause an elaboration error.
REQ-004 clk  input  1  core clock; all logic SHALL be clocked on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ena  input  1  start request; accepted only while rdy=1.
REQ-007 rdy  output  1  idle, may accept ena; dout holds last result.
REQ-008 last  output  1  final compute cycle; done follows next cycle.
REQ-009 done  output  1  one-cycle pulse; dout holds a new result.
REQ-010 din  input  512  LPS input; 64-bit word k = din[64k+63:64k].
REQ-011 dout  output  512  LPS result, same word layout.

Function
REQ-012 Transform SHALL be dout = L(P(S(din))) per GOST R 34.11-2012: byte S-box, byte-matrix transpose, 64x64 GF(2) A-matrix per word.
REQ-013 Accept SHALL occur on a cycle with ena=1, rdy=1, rst=0; rdy SHALL be 0 from the next cycle.
REQ-014 FSM states: IDLE (rdy=1), RUN (PS/L counters advance), FLUSH (1 cycle, last=1, ROM pipeline drain).
REQ-015 Transitions: IDLE->RUN on accept; RUN->FLUSH when ps_cnt=PS_STAGES-1 and l_cnt=L_STAGES-1; FLUSH->IDLE unconditionally.
REQ-016 l_cnt SHALL step every RUN cycle and wrap to 0; ps_cnt SHALL step when l_cnt wraps.
REQ-017 Each RUN cycle SHALL produce PS_W x L_B output bits; each bit is the XOR-reduce of (A-row & S-word).
REQ-018 Latency accept to done SHALL be exactly PS_STAGES*L_STAGES + 2 cycles.
REQ-019 done SHALL pulse in the cycle rdy returns to 1; dout SHALL be stable from done until the next accepted result.
REQ-020 Back-to-back: ena=1 in the done cycle SHALL be accepted; throughput is one result per PS_STAGES*L_STAGES+2 cycles.
REQ-021 ena while rdy=0 SHALL be ignored; it SHALL NOT be queued.
REQ-022 When PS_STAGES=1 or L_STAGES=1, the counter for that stage SHALL be absent; RUN SHALL then last L_STAGES or PS_STAGES cycles respectively.
REQ-023 dout bits not yet written in the current operation SHALL keep their previous value.

Reset
REQ-024 rst=1 SHALL force IDLE, rdy=1, last=0, done=0, counters=0, dout=0 in the next cycle, from any state.
REQ-025 rst during RUN or FLUSH SHALL abort the operation with no done pulse.
REQ-026 rst has priority over ena in the same cycle.

Configuration
REQ-027 Macro STREEBOG_LPS_DIN_REG_EN defined: din SHALL be captured into an internal 512-bit register at accept; din may change freely afterwards.
REQ-028 Macro undefined: no capture register; din SHALL be held stable from accept until done; cycle timing SHALL be identical.

Structure
REQ-029 Package streebog_lps_pkg SHALL hold legality checks, the PS_W/L_B derivation functions, counter-width functions and the FSM state enum.
REQ-030 The existing streebog_rom_s_table and streebog_rom_a_matrix ROMs SHALL be reused.
REQ-031 Sub-module streebog_lps_ctrl SHALL hold the FSM, counters, rdy/last/done and delayed write offsets.
REQ-032 The datapath (ROMs, XOR-reduce, write-back) SHALL stay in the top module.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Defaults, din = GOST R 34.11-2012 example 1 intermediate -> dout matches golden C model; done exactly 66 cycles after accept.
- Sweep PS_STAGES x L_STAGES over {1,2,4,8}x{1,2,8,64} with 100 random vectors each -> bit-exact match; latency = PS*L+2 (e.g. 1x1 -> 3, 8x64 -> 514).
- Two vectors, second ena in the done cycle -> both results correct; done pulses 66 cycles apart.
- rst asserted at RUN cycle 10 -> next cycle rdy=1, dout=0, no done; a fresh accept then gives the correct result.
- With STREEBOG_LPS_DIN_REG_EN, din randomised every cycle after accept -> result from the accept-cycle din; without the macro, din held -> same result.
- ena pulsed during RUN -> ignored; exactly one done pulse.
